clk_gate_arbiter: RTL and testbench

- Parametrised successor to the single-channel clock gater/activation path.
- Manages N_CH processing cores: per-core clock gating, sequenced reset release, drain-before-gate on finish.
- Round-robin admission limits concurrently clocked cores to MAX_ACTIVE (power budget).
- Sits between the per-node self-awareness/activation logic (req, fin) and the cores' clock/reset pins.

---
 rtl/clk_gate_arbiter_if.sv | 25 ++
 rtl/clk_gate_arbiter.sv | 150 +++++++++++++++
 tb/tb_clk_gate_arbiter.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/clk_gate_arbiter_if.sv
// Activation-side bundle for clk_gate_arbiter: per-core requests/finish pulses in,
// per-core clock, reset and status out.
interface clk_gate_arbiter_if #(
   parameter int unsigned N_CH  = 4,
   parameter int unsigned CNT_W = $clog2(N_CH + 1)
) ();
   logic [N_CH-1:0]  req;
   logic [N_CH-1:0]  fin;
   logic [N_CH-1:0]  clk_gated;
   logic [N_CH-1:0]  clk_en;
   logic [N_CH-1:0]  res_n_gated;
   logic [N_CH-1:0]  grant;
   logic [N_CH-1:0]  busy;
   logic [CNT_W-1:0] active_cnt;

   modport master (
      output req, fin,
      input  clk_gated, clk_en, res_n_gated, grant, busy, active_cnt
   );

   modport slave (
      input  req, fin,
      output clk_gated, clk_en, res_n_gated, grant, busy, active_cnt
   );
endinterface

// File: rtl/clk_gate_arbiter.sv
// Per-core clock gating with sequenced reset release, drain-before-gate and round-robin
// admission capped at MAX_ACTIVE concurrently clocked cores.
module clk_gate_arbiter #(
   parameter int unsigned N_CH         = 4,
   parameter int unsigned MAX_ACTIVE   = 4,
   parameter int unsigned RST_CYCLES   = 4,
   parameter int unsigned DRAIN_CYCLES = 2,
   parameter int unsigned CNT_W        = $clog2(N_CH + 1)
) (
   input logic               clk,
   input logic               res_n,
   clk_gate_arbiter_if.slave bus
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_PEND  = 3'd1;
   localparam logic [2:0] ST_RST   = 3'd2;
   localparam logic [2:0] ST_RUN   = 3'd3;
   localparam logic [2:0] ST_DRAIN = 3'd4;

   // The grant cycle counts as the first reset cycle, so RST itself lasts RST_CYCLES-1
   // (minimum one) and res_n_gated rises RST_CYCLES cycles after the grant.
   localparam int unsigned RST_LOAD   = (RST_CYCLES > 2) ? RST_CYCLES - 2 : 0;
   localparam int unsigned DRAIN_LOAD = DRAIN_CYCLES - 1;
   localparam int unsigned TMR_MAX    = (RST_LOAD > DRAIN_LOAD) ? RST_LOAD : DRAIN_LOAD;
   localparam int unsigned TMR_W      = (TMR_MAX > 1) ? $clog2(TMR_MAX + 1) : 1;
   localparam int unsigned PTR_W      = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int unsigned SUM_W      = PTR_W + 1;

   localparam logic [TMR_W-1:0] RST_LOAD_T   = TMR_W'(RST_LOAD);
   localparam logic [TMR_W-1:0] DRAIN_LOAD_T = TMR_W'(DRAIN_LOAD);

   logic [N_CH-1:0][2:0]       state_q, state_d;
   logic [N_CH-1:0][TMR_W-1:0] tmr_q, tmr_d;
   logic [PTR_W-1:0]           rr_q, rr_d;
   logic [CNT_W-1:0]           active_cnt_q, active_cnt_d;
   logic [N_CH-1:0]            clk_en_q, res_n_gated_q, busy_q;
   logic [N_CH-1:0]            busy_d, rel_d;
   logic [N_CH-1:0]            elig, grant_c;
   logic                       gnt_vld;
   logic [PTR_W-1:0]           gnt_idx, cand;
   logic [SUM_W-1:0]           sum;
   logic [N_CH-1:0]            en_lat;

   // Round-robin search over PEND channels still requesting, gated by the registered count.
   always_comb begin
      elig    = '0;
      gnt_vld = 1'b0;
      gnt_idx = '0;
      sum     = '0;
      cand    = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         elig[i] = (state_q[i] == ST_PEND) && bus.req[i];
      end
      if (32'(active_cnt_q) < MAX_ACTIVE) begin
         for (int unsigned k = 0; k < N_CH; k++) begin
            sum  = {1'b0, rr_q} + SUM_W'(k);
            cand = (sum >= SUM_W'(N_CH)) ? PTR_W'(sum - SUM_W'(N_CH)) : sum[PTR_W-1:0];
            if (!gnt_vld && elig[cand]) begin
               gnt_vld = 1'b1;
               gnt_idx = cand;
            end
         end
      end
      grant_c = gnt_vld ? (N_CH'(1) << gnt_idx) : '0;
      rr_d    = rr_q;
      if (gnt_vld) begin
         rr_d = (gnt_idx == PTR_W'(N_CH - 1)) ? '0 : gnt_idx + PTR_W'(1);
      end
   end

   always_comb begin
      state_d      = state_q;
      tmr_d        = tmr_q;
      busy_d       = '0;
      rel_d        = '0;
      active_cnt_d = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         case (state_q[i])
            ST_IDLE: begin
               if (bus.req[i]) state_d[i] = ST_PEND;
            end
            ST_PEND: begin
               if (!bus.req[i]) begin
                  state_d[i] = ST_IDLE;
               end else if (grant_c[i]) begin
                  state_d[i] = ST_RST;
                  tmr_d[i]   = RST_LOAD_T;
               end
            end
            ST_RST: begin
               if (tmr_q[i] == '0) state_d[i] = ST_RUN;
               else                tmr_d[i]   = tmr_q[i] - TMR_W'(1);
            end
            ST_RUN: begin
               if (bus.fin[i] || !bus.req[i]) begin
                  state_d[i] = ST_DRAIN;
                  tmr_d[i]   = DRAIN_LOAD_T;
               end
            end
            ST_DRAIN: begin
               if (tmr_q[i] == '0) state_d[i] = ST_IDLE;
               else                tmr_d[i]   = tmr_q[i] - TMR_W'(1);
            end
            default: state_d[i] = ST_IDLE;
         endcase
         busy_d[i]    = (state_d[i] == ST_RST) || (state_d[i] == ST_RUN) ||
                        (state_d[i] == ST_DRAIN);
         rel_d[i]     = (state_d[i] == ST_RUN) || (state_d[i] == ST_DRAIN);
         active_cnt_d = active_cnt_d + CNT_W'(busy_d[i]);
      end
   end

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         state_q       <= '0;
         tmr_q         <= '0;
         rr_q          <= '0;
         active_cnt_q  <= '0;
         clk_en_q      <= '0;
         res_n_gated_q <= '0;
         busy_q        <= '0;
      end else begin
         state_q       <= state_d;
         tmr_q         <= tmr_d;
         rr_q          <= rr_d;
         active_cnt_q  <= active_cnt_d;
         clk_en_q      <= busy_d;
         res_n_gated_q <= rel_d;
         busy_q        <= busy_d;
      end
   end

   // Enable latch is transparent only while clk is low, so the gated high phase is never cut.
   always_latch begin
      if (!res_n) begin
         en_lat = '0;
      end else if (!clk) begin
         en_lat = clk_en_q;
      end
   end

   assign bus.clk_gated   = {N_CH{clk}} & en_lat;
   assign bus.clk_en      = clk_en_q;
   assign bus.res_n_gated = res_n_gated_q;
   assign bus.busy        = busy_q;
   assign bus.active_cnt  = active_cnt_q;
   assign bus.grant       = grant_c;

endmodule

// File: tb/tb_clk_gate_arbiter.sv
// Directed bench for clk_gate_arbiter (N_CH=4, MAX_ACTIVE=2, RST_CYCLES=4, DRAIN_CYCLES=2).
module tb_clk_gate_arbiter;
   localparam int unsigned N_CH         = 4;
   localparam int unsigned MAX_ACTIVE   = 2;
   localparam int unsigned RST_CYCLES   = 4;
   localparam int unsigned DRAIN_CYCLES = 2;
   localparam int unsigned CNT_W        = $clog2(N_CH + 1);

   logic        clk   = 1'b0;
   logic        res_n = 1'b0;
   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   clk_gate_arbiter_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus ();

   clk_gate_arbiter #(
      .N_CH         (N_CH),
      .MAX_ACTIVE   (MAX_ACTIVE),
      .RST_CYCLES   (RST_CYCLES),
      .DRAIN_CYCLES (DRAIN_CYCLES),
      .CNT_W        (CNT_W)
   ) dut (
      .clk   (clk),
      .res_n (res_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Gated-clock pulse width monitor: every high phase must be exactly half a period.
   logic [N_CH-1:0] cg_prev = '0;
   longint          rise_t [N_CH];
   int unsigned     glitches   = 0;
   int unsigned     rst_pulses = 0;

   always @(bus.clk_gated) begin
      for (int i = 0; i < int'(N_CH); i++) begin
         if (bus.clk_gated[i] === 1'b1 && cg_prev[i] == 1'b0) begin
            rise_t[i] = longint'($time);
            if (!res_n) rst_pulses++;
         end
         if (bus.clk_gated[i] === 1'b0 && cg_prev[i] == 1'b1) begin
            if (longint'($time) - rise_t[i] != 5) glitches++;
         end
      end
      cg_prev = bus.clk_gated;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   // Drive point of the next cycle; checks follow a further #1.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      @(negedge clk);
      res_n   = 1'b0;
      bus.req = '0;
      bus.fin = '0;
      @(negedge clk);
      @(negedge clk);
      res_n = 1'b1;
   endtask

   int unsigned nz_cycles;
   int unsigned exp_idx;
   int unsigned n_gr;
   int unsigned max_act;

   initial begin
      bus.req = '0;
      bus.fin = '0;

      // Reset held while req toggles.
      for (int c = 0; c < 4; c++) begin
         step();
         bus.req = ~bus.req;
      end
      #1;
      check_eq("a_rst_clk_en", bus.clk_en, 0);
      check_eq("a_rst_res_n_gated", bus.res_n_gated, 0);
      check_eq("a_rst_grant", bus.grant, 0);
      check_eq("a_rst_busy", bus.busy, 0);
      check_eq("a_rst_active_cnt", bus.active_cnt, 0);
      @(posedge clk);
      #1;
      check_eq("a_rst_clk_gated", bus.clk_gated, 0);
      check_eq("a_rst_pulses", rst_pulses, 0);
      bus.req = '0;
      @(negedge clk);
      res_n     = 1'b1;
      nz_cycles = 0;
      for (int c = 0; c < 100; c++) begin
         step();
         #1;
         if ((bus.clk_en | bus.res_n_gated | bus.grant | bus.busy) != '0 ||
             bus.active_cnt != '0 || bus.clk_gated != '0) nz_cycles++;
      end
      check_eq("a_idle_100", nz_cycles, 0);

      // Single channel: req in cycle 0.
      step(); bus.req = 4'b0001; #1;
      check_eq("b_c0_grant", bus.grant, 0);
      step(); #1;
      check_eq("b_c1_grant", bus.grant, 4'b0001);
      check_eq("b_c1_clk_en", bus.clk_en, 0);
      step(); #1;
      check_eq("b_c2_clk_en", bus.clk_en, 4'b0001);
      check_eq("b_c2_res_n_gated", bus.res_n_gated, 0);
      check_eq("b_c2_active_cnt", bus.active_cnt, 1);
      step(); step(); #1;
      check_eq("b_c4_res_n_gated", bus.res_n_gated, 0);
      step(); #1;
      check_eq("b_c5_res_n_gated", bus.res_n_gated, 4'b0001);
      repeat (15) step();
      bus.fin = 4'b0001;
      step(); bus.fin = '0;
      step(); #1;
      check_eq("b_c22_clk_en", bus.clk_en, 4'b0001);
      check_eq("b_c22_res_n_gated", bus.res_n_gated, 4'b0001);
      step(); #1;
      check_eq("b_c23_clk_en", bus.clk_en, 0);
      check_eq("b_c23_res_n_gated", bus.res_n_gated, 0);
      check_eq("b_c23_no_reentry", bus.grant, 0);
      step(); #1;
      check_eq("b_c24_regrant", bus.grant, 4'b0001);
      bus.req = '0;
      step(); #1;
      check_eq("b_c25_withdrawn", bus.busy, 0);

      // Budget: four simultaneous requests, two slots.
      do_reset();
      step(); bus.req = 4'b1111;
      step(); #1;
      check_eq("c_c1_grant", bus.grant, 4'b0001);
      step(); #1;
      check_eq("c_c2_grant", bus.grant, 4'b0010);
      check_eq("c_c2_active_cnt", bus.active_cnt, 1);
      step(); #1;
      check_eq("c_c3_grant", bus.grant, 0);
      check_eq("c_c3_active_cnt", bus.active_cnt, 2);
      step(); #1;
      check_eq("c_c4_busy", bus.busy, 4'b0011);
      repeat (6) step();
      bus.fin = 4'b0001;
      step(); bus.fin = '0;
      step(); #1;
      check_eq("c_c12_grant", bus.grant, 0);
      step(); #1;
      check_eq("c_c13_grant", bus.grant, 4'b0100);
      check_eq("c_c13_active_cnt", bus.active_cnt, 1);
      step(); #1;
      check_eq("c_c14_active_cnt", bus.active_cnt, 2);
      step(); step();
      bus.fin = 4'b0010;
      step(); bus.fin = '0;
      step(); #1;
      check_eq("c_c18_grant", bus.grant, 0);
      step(); #1;
      check_eq("c_c19_grant", bus.grant, 4'b1000);
      step(); #1;
      check_eq("c_c20_busy", bus.busy, 4'b1100);
      check_eq("c_c20_active_cnt", bus.active_cnt, 2);

      // Fairness: continuous requests, every run finished immediately.
      do_reset();
      step(); bus.req = '1; bus.fin = '1;
      exp_idx = 0;
      n_gr    = 0;
      max_act = 0;
      for (int c = 0; c < 400 && n_gr < 50; c++) begin
         step(); #1;
         if (32'(bus.active_cnt) > max_act) max_act = 32'(bus.active_cnt);
         if (bus.grant != '0) begin
            check_eq("d_rr_order", 32'(bus.grant), 32'd1 << exp_idx);
            exp_idx = (exp_idx + 1) % N_CH;
            n_gr++;
         end
      end
      check_eq("d_grant_total", n_gr, 50);
      check_eq("d_max_active", max_act, MAX_ACTIVE);

      // Withdraw, fin during RST, early stop by req drop.
      do_reset();
      step(); bus.req = 4'b1001;
      step(); #1;
      check_eq("e_c1_grant", bus.grant, 4'b0001);
      step(); #1;
      check_eq("e_c2_grant", bus.grant, 4'b1000);
      step(); bus.req = 4'b1111; bus.fin = 4'b1000; #1;
      check_eq("e_c3_grant", bus.grant, 0);
      step(); bus.fin = '0; #1;
      check_eq("e_c4_grant", bus.grant, 0);
      step(); bus.req = 4'b1101; #1;
      check_eq("e_c5_grant", bus.grant, 0);
      step(); #1;
      check_eq("e_c6_res_n_gated", bus.res_n_gated, 4'b1001);
      step(); bus.req = 4'b1100; #1;
      check_eq("e_c7_grant", bus.grant, 0);
      step(); #1;
      check_eq("e_c8_clk_en", bus.clk_en, 4'b1001);
      step(); step(); #1;
      check_eq("e_c10_grant", bus.grant, 4'b0100);
      check_eq("e_c10_busy", bus.busy, 4'b1000);
      repeat (4) step();
      #1;
      check_eq("e_c14_res_n_gated", bus.res_n_gated, 4'b1100);
      step(); bus.req = 4'b1000;
      step(); step(); #1;
      check_eq("e_c17_clk_en", bus.clk_en, 4'b1100);
      check_eq("e_c17_res_n_gated", bus.res_n_gated, 4'b1100);
      step(); #1;
      check_eq("e_c18_clk_en", bus.clk_en, 4'b1000);
      check_eq("e_c18_busy", bus.busy, 4'b1000);
      check_eq("e_c18_active_cnt", bus.active_cnt, 1);

      // Async reset with two channels running.
      bus.req = 4'b1001;
      repeat (7) step();
      #1;
      check_eq("f_pre_active_cnt", bus.active_cnt, 2);
      check_eq("f_pre_res_n_gated", bus.res_n_gated, 4'b1001);
      @(negedge clk);
      res_n = 1'b0;
      #1;
      check_eq("f_clk_en", bus.clk_en, 0);
      check_eq("f_res_n_gated", bus.res_n_gated, 0);
      check_eq("f_active_cnt", bus.active_cnt, 0);
      check_eq("f_busy", bus.busy, 0);
      @(posedge clk);
      #1;
      check_eq("f_clk_gated_held", bus.clk_gated, 0);
      bus.req = '0;
      @(negedge clk);
      res_n = 1'b1;
      step(); #1;
      check_eq("f_glitches", glitches, 0);
      check_eq("f_rst_pulses", rst_pulses, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
